// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I-subset datapath with stalling memories.
// Outputs are combinational from state/IR; a sticky halt is taken on illegal ops or mem_ready timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic       is_r, is_i, is_lw, is_sw, is_beq, legal, retire;
  logic [3:0] funct_alu;

  always_comb begin
    is_r   = (opcode == OP_R);
    is_i   = (opcode == OP_I);
    is_lw  = (opcode == OP_LW) && (funct3 == 3'b010);
    is_sw  = (opcode == OP_SW) && (funct3 == 3'b010);
    is_beq = (opcode == OP_BEQ) && (funct3 == 3'b000);
    legal  = 1'b0;
    if (is_r)
      legal = (funct3 == 3'b000) || (!funct7_5 && (funct3 == 3'b110 || funct3 == 3'b111));
    else if (is_i)
      legal = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else
      legal = is_lw || is_sw || is_beq;

    // SUB only exists in the R-type encoding; I-type with funct7_5 set stays ADD.
    case (funct3)
      3'b111:  funct_alu = ALU_AND;
      3'b110:  funct_alu = ALU_OR;
      default: funct_alu = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    retire      = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = '0;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        if (is_r) begin
          alu_control = funct_alu;
          state_d     = S_WB;
        end else if (is_i) begin
          alu_src_b   = 2'b10;
          alu_control = funct_alu;
          state_d     = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_beq) begin
          alu_control = ALU_SUB;
          pc_write    = zero;
          pc_src      = zero;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_MEM: begin
        mem_write = is_sw;
        mem_read  = !is_sw;
        if (mem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    retired_d = retire ? retired_q + 1'b1 : retired_q;

    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks with hand-computed expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic        mem_read, mem_write, mem_to_reg, reg_write;
  logic [2:0]  state;
  logic        illegal, bus_err;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state(state), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f75;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    next_cyc(); #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read_forced got=%b exp=0", mem_read); end
    checks++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL rst_enables_forced got=%b%b exp=00", ir_write, pc_write); end
    next_cyc(); reset = 1'b0; #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (retired !== 32'd0 || illegal !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_regs got ret=%0d ill=%b berr=%b exp 0/0/0", retired, illegal, bus_err); end
    checks++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01) begin errors++; $display("FAIL fetch_out got rd=%b b=%b exp 1/01", mem_read, alu_src_b); end
  endtask

  task automatic test_add();
    set_instr(7'b0110011, 3'b000, 1'b0); mem_ready = 1'b1; #1;
    checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0) begin errors++; $display("FAIL add_fetch got ir=%b pc=%b src=%b exp 1/1/0", ir_write, pc_write, pc_src); end
    next_cyc(); #1;
    checks++; if (state !== 3'd1 || alu_src_a !== 2'b10 || alu_src_b !== 2'b10) begin errors++; $display("FAIL add_decode got st=%0d a=%b b=%b exp 1/10/10", state, alu_src_a, alu_src_b); end
    next_cyc(); #1;
    checks++; if (state !== 3'd2 || alu_control !== 4'b0010 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin errors++; $display("FAIL add_exec got st=%0d alu=%b a=%b b=%b exp 2/0010/01/00", state, alu_control, alu_src_a, alu_src_b); end
    next_cyc(); #1;
    checks++; if (state !== 3'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin errors++; $display("FAIL add_wb got st=%0d rw=%b m2r=%b exp 4/1/0", state, reg_write, mem_to_reg); end
    next_cyc(); #1;
    checks++; if (state !== 3'd0 || retired !== 32'd1) begin errors++; $display("FAIL add_done got st=%0d ret=%0d exp 0/1", state, retired); end
  endtask

  task automatic test_lw_stall();
    int start;
    start = cyc;
    set_instr(7'b0000011, 3'b010, 1'b0); mem_ready = 1'b1; #1;
    next_cyc(); next_cyc(); #1;
    checks++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || alu_control !== 4'b0010) begin errors++; $display("FAIL lw_exec got a=%b b=%b alu=%b exp 01/10/0010", alu_src_a, alu_src_b, alu_control); end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cyc(); #1;
      checks++; if (state !== 3'd3 || mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL lw_mem_wait%0d got st=%0d rd=%b wr=%b exp 3/1/0", i, state, mem_read, mem_write); end
    end
    next_cyc(); mem_ready = 1'b1; #1;
    checks++; if (state !== 3'd3 || mem_read !== 1'b1) begin errors++; $display("FAIL lw_mem_last got st=%0d rd=%b exp 3/1", state, mem_read); end
    next_cyc(); #1;
    checks++; if (state !== 3'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b1) begin errors++; $display("FAIL lw_wb got st=%0d rw=%b m2r=%b exp 4/1/1", state, reg_write, mem_to_reg); end
    next_cyc(); #1;
    checks++; if (cyc - start !== 8 || state !== 3'd0 || retired !== 32'd2) begin errors++; $display("FAIL lw_done got cycles=%0d st=%0d ret=%0d exp 8/0/2", cyc - start, state, retired); end
  endtask

  task automatic test_beq();
    int start;
    set_instr(7'b1100011, 3'b000, 1'b0); mem_ready = 1'b1; zero = 1'b1;
    start = cyc;
    next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd2 || pc_write !== 1'b1 || pc_src !== 1'b1 || alu_control !== 4'b0110) begin errors++; $display("FAIL beq_taken got st=%0d pw=%b src=%b alu=%b exp 2/1/1/0110", state, pc_write, pc_src, alu_control); end
    next_cyc(); #1;
    checks++; if (cyc - start !== 3 || state !== 3'd0 || retired !== 32'd3) begin errors++; $display("FAIL beq_taken_done got cycles=%0d st=%0d ret=%0d exp 3/0/3", cyc - start, state, retired); end
    zero = 1'b0;
    start = cyc;
    next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd2 || pc_write !== 1'b0 || alu_control !== 4'b0110) begin errors++; $display("FAIL beq_not_taken got st=%0d pw=%b alu=%b exp 2/0/0110", state, pc_write, alu_control); end
    next_cyc(); #1;
    checks++; if (cyc - start !== 3 || state !== 3'd0 || retired !== 32'd4) begin errors++; $display("FAIL beq_nt_done got cycles=%0d st=%0d ret=%0d exp 3/0/4", cyc - start, state, retired); end
  endtask

  task automatic test_sub_ori();
    set_instr(7'b0110011, 3'b000, 1'b1); mem_ready = 1'b1;
    next_cyc(); next_cyc(); #1;
    checks++; if (alu_control !== 4'b0110 || alu_src_b !== 2'b00) begin errors++; $display("FAIL sub_exec got alu=%b b=%b exp 0110/00", alu_control, alu_src_b); end
    next_cyc(); next_cyc();
    set_instr(7'b0010011, 3'b110, 1'b0);
    next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd2 || alu_control !== 4'b0001 || alu_src_b !== 2'b10 || alu_src_a !== 2'b01) begin errors++; $display("FAIL ori_exec got st=%0d alu=%b a=%b b=%b exp 2/0001/01/10", state, alu_control, alu_src_a, alu_src_b); end
    next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd0 || retired !== 32'd6) begin errors++; $display("FAIL ori_done got st=%0d ret=%0d exp 0/6", state, retired); end
  endtask

  task automatic test_sw();
    set_instr(7'b0100011, 3'b010, 1'b0); mem_ready = 1'b1;
    next_cyc(); next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd3 || mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL sw_mem got st=%0d wr=%b rd=%b exp 3/1/0", state, mem_write, mem_read); end
    next_cyc(); #1;
    checks++; if (state !== 3'd0 || retired !== 32'd7) begin errors++; $display("FAIL sw_done got st=%0d ret=%0d exp 0/7", state, retired); end
  endtask

  task automatic test_illegal();
    set_instr(7'b1101111, 3'b000, 1'b0); mem_ready = 1'b1;
    next_cyc(); #1;
    checks++; if (state !== 3'd1 || illegal !== 1'b0) begin errors++; $display("FAIL jal_decode got st=%0d ill=%b exp 1/0", state, illegal); end
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #1;
      checks++; if (state !== 3'd7 || illegal !== 1'b1 || mem_read !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0 || retired !== 32'd7) begin errors++; $display("FAIL jal_halt%0d got st=%0d ill=%b rd=%b pw=%b ir=%b ret=%0d exp 7/1/0/0/0/7", i, state, illegal, mem_read, pc_write, ir_write, retired); end
    end
    reset = 1'b1; next_cyc(); reset = 1'b0; #1;
    checks++; if (state !== 3'd0 || illegal !== 1'b0 || retired !== 32'd0) begin errors++; $display("FAIL jal_reset got st=%0d ill=%b ret=%0d exp 0/0/0", state, illegal, retired); end
  endtask

  task automatic test_timeout();
    set_instr(7'b0110011, 3'b000, 1'b0); mem_ready = 1'b0;
    for (int i = 1; i < 16; i++) next_cyc();
    #1;
    checks++; if (state !== 3'd0 || bus_err !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL to_cycle16 got st=%0d berr=%b rd=%b exp 0/0/1", state, bus_err, mem_read); end
    next_cyc(); #1;
    checks++; if (state !== 3'd7 || bus_err !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL to_halt got st=%0d berr=%b rd=%b exp 7/1/0", state, bus_err, mem_read); end
    reset = 1'b1; next_cyc(); reset = 1'b0; #1;
    checks++; if (state !== 3'd0 || bus_err !== 1'b0) begin errors++; $display("FAIL to_reset got st=%0d berr=%b exp 0/0", state, bus_err); end
    for (int i = 1; i < 16; i++) next_cyc();
    mem_ready = 1'b1; #1;
    checks++; if (state !== 3'd0 || ir_write !== 1'b1) begin errors++; $display("FAIL to_last_ok got st=%0d ir=%b exp 0/1", state, ir_write); end
    next_cyc(); #1;
    checks++; if (state !== 3'd1 || bus_err !== 1'b0) begin errors++; $display("FAIL to_decode got st=%0d berr=%b exp 1/0", state, bus_err); end
    next_cyc(); next_cyc(); next_cyc(); #1;
    checks++; if (state !== 3'd0 || retired !== 32'd1) begin errors++; $display("FAIL to_add_done got st=%0d ret=%0d exp 0/1", state, retired); end
  endtask

  task automatic test_reset_in_sw();
    set_instr(7'b0100011, 3'b010, 1'b0); mem_ready = 1'b1;
    next_cyc(); next_cyc(); mem_ready = 1'b0;
    next_cyc(); #1;
    checks++; if (state !== 3'd3 || mem_write !== 1'b1) begin errors++; $display("FAIL rsw_mem got st=%0d wr=%b exp 3/1", state, mem_write); end
    next_cyc(); reset = 1'b1; #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rsw_write_drop got wr=%b exp 0", mem_write); end
    next_cyc(); reset = 1'b0; #1;
    checks++; if (state !== 3'd0 || retired !== 32'd0 || illegal !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rsw_after got st=%0d ret=%0d ill=%b berr=%b exp 0/0/0/0", state, retired, illegal, bus_err); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_beq();
    test_sub_ori();
    test_sw();
    test_illegal();
    test_timeout();
    test_reset_in_sw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
